// File: rtl/counter_pkg.sv
// Shared types and default sizes for the up/down counter sweep sequencer.
//   state_t   : sequencer FSM states
//   *_DEF     : default widths used by counter_sweep_ctrl
package counter_pkg;
  localparam int W_DEF     = 4;
  localparam int DIV_W_DEF = 8;
  localparam int NSW_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, LOAD, UP, DOWN} state_t;
endpackage

// File: rtl/step_tick.sv
// Step prescaler: raises tick on every (div+1)-th cycle in which run is high.
//   clk, rst : clock, async active-high reset
//   clear    : restart the prescaler from 0
//   run      : advance the prescaler; low freezes it at its current value
//   div      : period minus one
//   tick     : combinational, high on the cycle the prescaler equals div
module step_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] pre;

  assign tick = run && (pre == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pre <= '0;
    else if (clear) pre <= '0;
    else if (run)   pre <= tick ? '0 : pre + 1'b1;
  end
endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that drives an external up/down counter through ping-pong sweeps
// lo_bound -> hi_bound -> lo_bound, num_sweeps times (0 = until abort), one
// step every step_div+1 cycles. count_in is the counter's output and is used
// to decide when to turn around.
//   clk, reset            : clock, async active-high reset
//   start/abort/pause     : control (start sampled in IDLE, abort wins all)
//   lo_bound, hi_bound,
//   num_sweeps, step_div  : sweep parameters, latched on an accepted start
//   count_in              : counter feedback
//   ctr_*                 : counter enable / set / set_value / up_down
//   busy, done, aborted,
//   err, sweep_cnt        : status (done/aborted/err are 1-cycle pulses)
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int NSW_W = NSW_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [W-1:0]     lo_bound,
  input  logic [W-1:0]     hi_bound,
  input  logic [NSW_W-1:0] num_sweeps,
  input  logic [DIV_W-1:0] step_div,
  input  logic [W-1:0]     count_in,
  output logic             ctr_enable,
  output logic             ctr_set,
  output logic [W-1:0]     ctr_set_value,
  output logic             ctr_up_down,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [NSW_W-1:0] sweep_cnt
);
  state_t           state;
  logic [W-1:0]     lo_q, hi_q;
  logic [NSW_W-1:0] num_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             stepping;
  logic             at_top, at_bot, last_sweep;

  assign stepping = (state == UP) || (state == DOWN);

  // Prescaler only runs while sweeping; LOAD and IDLE hold it at 0 so the
  // first step lands a fixed step_div+1 cycles after entering UP.
  step_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (reset),
    .clear (!stepping),
    .run   (busy && !pause),
    .div   (div_q),
    .tick  (tick)
  );

  // Decisions use the pre-step count at the edge where the registered enable
  // actually makes the counter move.
  assign at_top     = (count_in == hi_q - W'(1));
  assign at_bot     = (count_in == lo_q + W'(1));
  assign last_sweep = (num_q != '0) && (sweep_cnt + NSW_W'(1) == num_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      num_q         <= '0;
      div_q         <= '0;
      ctr_enable    <= 1'b0;
      ctr_set       <= 1'b0;
      ctr_set_value <= '0;
      ctr_up_down   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err           <= 1'b0;
      sweep_cnt     <= '0;
    end else begin
      ctr_set <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        ctr_enable <= 1'b0;
        busy       <= 1'b0;
        aborted    <= busy;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (lo_bound < hi_bound) begin
                lo_q          <= lo_bound;
                hi_q          <= hi_bound;
                num_q         <= num_sweeps;
                div_q         <= step_div;
                sweep_cnt     <= '0;
                ctr_set       <= 1'b1;
                ctr_set_value <= lo_bound;
                busy          <= 1'b1;
                state         <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD: begin
            ctr_up_down <= 1'b1;
            state       <= UP;
          end
          UP: begin
            ctr_enable <= tick;
            if (ctr_enable && at_top) begin
              state       <= DOWN;
              ctr_up_down <= 1'b0;
            end
          end
          DOWN: begin
            ctr_enable <= tick;
            if (ctr_enable && at_bot) begin
              sweep_cnt <= sweep_cnt + NSW_W'(1);
              if (last_sweep) begin
                state      <= IDLE;
                ctr_enable <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                state       <= UP;
                ctr_up_down <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a behavioural up/down counter.
module tb_counter_sweep_ctrl;
  localparam int W = 4, DIV_W = 8, NSW_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, abort, pause;
  logic [W-1:0]     lo_bound, hi_bound, count_in;
  logic [NSW_W-1:0] num_sweeps;
  logic [DIV_W-1:0] step_div;
  logic             ctr_enable, ctr_set, ctr_up_down;
  logic [W-1:0]     ctr_set_value;
  logic             busy, done, aborted, err;
  logic [NSW_W-1:0] sweep_cnt;

  counter_sweep_ctrl #(.W(W), .DIV_W(DIV_W), .NSW_W(NSW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .lo_bound(lo_bound), .hi_bound(hi_bound), .num_sweeps(num_sweeps),
    .step_div(step_div), .count_in(count_in),
    .ctr_enable(ctr_enable), .ctr_set(ctr_set), .ctr_set_value(ctr_set_value),
    .ctr_up_down(ctr_up_down), .busy(busy), .done(done), .aborted(aborted),
    .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Counter model: set wins, else step by up_down; never reset by the sequencer.
  logic [W-1:0] cnt = '0;
  assign count_in = cnt;
  always @(posedge clk) begin
    if (ctr_set)         cnt <= ctr_set_value;
    else if (ctr_enable) cnt <= ctr_up_down ? cnt + 4'd1 : cnt - 4'd1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Per-run statistics gathered by sweep()
  int done_at, busy_cyc, done_cnt, abt_cnt, err_cnt, set_cnt, en_cnt;
  int gap_bad, last_en, wrapped, cnt_p0, cnt_p1, en_in_pause, set_val0;
  int timed_out;
  int trace [0:127];

  // Pulse start with the given parameters, then step edge by edge (index i =
  // edge number after start) until busy drops or max_cyc edges have passed.
  task automatic sweep(input int lo_v, input int hi_v, input int num_v, input int div_v,
                       input int p_at, input int p_len, input int a_at, input int max_cyc);
    logic [W-1:0] prev;
    lo_bound = W'(lo_v); hi_bound = W'(hi_v);
    num_sweeps = NSW_W'(num_v); step_div = DIV_W'(div_v);
    start = 1'b1;
    done_at = -1; busy_cyc = 0; done_cnt = 0; abt_cnt = 0; err_cnt = 0; set_cnt = 0;
    en_cnt = 0; gap_bad = 0; last_en = -1; wrapped = 0; cnt_p0 = -1; cnt_p1 = -1;
    en_in_pause = 0; set_val0 = -1; timed_out = 1;
    prev = cnt;
    for (int i = 0; i < max_cyc; i++) begin
      pause = (i >= p_at) && (i < p_at + p_len);
      abort = (i == a_at);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      if (i < 128) trace[i] = int'(cnt);
      if (i == 0) set_val0 = int'(ctr_set_value);
      busy_cyc += int'(busy);
      if (done) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (aborted) abt_cnt++;
      if (err) err_cnt++;
      if (ctr_set) set_cnt++;
      if (ctr_enable) begin
        en_cnt++;
        if (last_en >= 0 && i - last_en != div_v + 1) gap_bad++;
        last_en = i;
        if (i >= p_at && i < p_at + p_len) en_in_pause++;
      end
      if (i == p_at) cnt_p0 = int'(cnt);
      if (i == p_at + p_len) cnt_p1 = int'(cnt);
      if ((prev == 4'd0 && cnt == 4'd15) || (prev == 4'd15 && cnt == 4'd0)) wrapped++;
      prev = cnt;
      if (!busy) begin timed_out = 0; break; end
    end
    pause = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, ctr_enable, ctr_set, ctr_set_value, ctr_up_down,
            busy, done, aborted, err, sweep_cnt};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    lo_bound = '0; hi_bound = '0; num_sweeps = '0; step_div = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 2..5..2 once, full speed
    sweep(2, 5, 1, 0, 1000, 0, 1000, 40);
    chk("t1_timeout", timed_out, 0);
    chk("t1_set_val", set_val0, 2);
    chk("t1_set_cnt", set_cnt, 1);
    begin
      int exp_tr [1:8] = '{2, 2, 3, 4, 5, 4, 3, 2};
      for (int k = 1; k <= 8; k++) chk($sformatf("t1_cnt%0d", k), trace[k], exp_tr[k]);
    end
    chk("t1_done_at", done_at, 8);
    chk("t1_busy_cyc", busy_cyc, 8);
    chk("t1_sweep_cnt", sweep_cnt, 1);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_cnt_hold", cnt, 2);

    // 2: empty and inverted ranges are rejected
    sweep(5, 5, 1, 0, 1000, 0, 1000, 4);
    chk("t2_err", err_cnt, 1);
    chk("t2_set", set_cnt, 0);
    chk("t2_busy", busy_cyc, 0);
    sweep(9, 3, 1, 0, 1000, 0, 1000, 4);
    chk("t2b_err", err_cnt, 1);
    chk("t2b_busy", busy_cyc, 0);

    // 3: full range twice, must never wrap
    sweep(0, 15, 2, 0, 1000, 0, 1000, 200);
    chk("t3_timeout", timed_out, 0);
    chk("t3_done_at", done_at, 62);
    chk("t3_wrap", wrapped, 0);
    chk("t3_sweep_cnt", sweep_cnt, 2);
    chk("t3_cnt_end", cnt, 0);

    // 4a: div=3 -> one enable every 4 cycles
    sweep(2, 5, 1, 3, 1000, 0, 1000, 200);
    chk("t4_done_at", done_at, 26);
    chk("t4_en_cnt", en_cnt, 6);
    chk("t4_en_gap", gap_bad, 0);
    // 4b: pause 10 cycles mid-UP stretches the run by exactly 10
    sweep(2, 5, 1, 3, 8, 10, 1000, 200);
    chk("t4p_cnt_p0", cnt_p0, 3);
    chk("t4p_cnt_p1", cnt_p1, 3);
    chk("t4p_en_pause", en_in_pause, 0);
    chk("t4p_done_at", done_at, 36);

    // 5: endless sweeps 1..3..1, abort during the 4th DOWN leg
    sweep(1, 3, 0, 0, 1000, 0, 17, 100);
    chk("t5_timeout", timed_out, 0);
    chk("t5_abt", abt_cnt, 1);
    chk("t5_done", done_cnt, 0);
    chk("t5_sweeps", sweep_cnt, 3);
    chk("t5_en", ctr_enable, 0);
    chk("t5_cnt", cnt, 2);
    repeat (3) @(posedge clk); #1;
    chk("t5_cnt_hold", cnt, 2);
    chk("t5_abt_pulse", aborted, 0);
    chk("t5_busy", busy, 0);

    // 6: async reset mid-UP, counter keeps value, restart reloads lo
    sweep(3, 9, 1, 1, 1000, 0, 1000, 7);
    chk("t6_cnt_pre", cnt, 5);
    chk("t6_busy_pre", busy, 1);
    reset = 1'b1;
    #1 chk("t6_reset_outs", outs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t6_cnt_kept", cnt, 5);
    sweep(3, 9, 1, 1, 1000, 0, 1000, 100);
    chk("t6_set_cnt", set_cnt, 1);
    chk("t6_set_val", set_val0, 3);
    chk("t6_reload", trace[1], 3);
    chk("t6_done_at", done_at, 26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
